mips_run_ctrl: RTL and testbench
================================

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum RUN cycles before an error is flagged.
REQ-003 SHALL have parameter CNT_W, default 16: cycle-counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port clk1, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high.
REQ-007 Port start, input, 1: begin a load/run sequence; sampled in IDLE, DONE, ERR.
REQ-008 Port abort, input, 1: return to IDLE from any state.
REQ-009 Port reg_init_en, input, 1: when high, the register-init phase runs after load.
REQ-010 Port prog_valid / prog_ready, input / output, 1 each: program-word stream handshake.
REQ-011 Port prog_data, input, 32: instruction word. Port prog_last, input, 1: final word of the program.
REQ-012 Port mem_we / mem_addr / mem_wdata, outputs, 1 / ADDR_W / 32: instruction-memory write port.
REQ-013 Port rf_we / rf_addr / rf_wdata, outputs, 1 / 5 / 32: register-file write port.
REQ-014 Port cpu_clear, output, 1: one-cycle pulse forcing PC=0, HALTED=0, TAKEN_BRANCH=0.
REQ-015 Port cpu_run, output, 1: enables the processor clocks. Port cpu_halted, input, 1: processor HALTED flag.
REQ-016 Ports busy / done / error, outputs, 1 each; err_code, output, 2; cycles, output, CNT_W.

Function
REQ-017 SHALL implement states IDLE, LOAD, RINIT, CLEAR, RUN, DONE, ERR; busy=1 in LOAD, RINIT, CLEAR, RUN.
REQ-018 IDLE/DONE/ERR with start=1 and abort=0: go to LOAD; clear word index, cycles, err_code, done, error.
REQ-019 LOAD: prog_ready=1; a beat is accepted when prog_valid&prog_ready.
REQ-020 Each accepted beat: next cycle mem_we=1, mem_addr=word index, mem_wdata=prog_data; index then increments. Write latency is 1 cycle.
REQ-021 Beat accepted with prog_last=1: go to RINIT if reg_init_en=1, else CLEAR.
REQ-022 Beat accepted at index 2^ADDR_W-1 with prog_last=0: go to ERR, err_code=1. If prog_last=1 on the same beat, prog_last wins and no error is raised.
REQ-023 RINIT: run exactly 31 consecutive cycles, rf_we=1, rf_addr=k, rf_wdata=k zero-extended, k=0..30 in order; then go to CLEAR.
REQ-024 CLEAR: exactly one cycle with cpu_clear=1 and cpu_run=0; then go to RUN.
REQ-025 RUN: cpu_run=1; cycles increments every RUN cycle and saturates at 2^CNT_W-1.
REQ-026 RUN with cpu_halted=1: go to DONE; cycles freezes at its value including that cycle; done=1 until the next start.
REQ-027 RUN with cycles reaching TIMEOUT and cpu_halted=0: go to ERR, err_code=2, cpu_run drops next cycle. If halted and timeout occur in the same cycle, halted wins.
REQ-028 abort=1 in any state: next cycle go to IDLE, all strobes and cpu_run=0, cycles/err_code held. abort overrides start.
REQ-029 mem_we, rf_we, cpu_clear SHALL be zero in every state and cycle not named in REQ-020, REQ-023, REQ-024.
REQ-030 prog_ready SHALL be 0 outside LOAD; beats presented outside LOAD are ignored.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 reset=1 SHALL immediately force state IDLE and all outputs, cycles and err_code to 0, including mid-LOAD and mid-RUN.
REQ-033 After reset deasserts, no action SHALL occur until start=1.

Verification
REQ-034 Load 9 words (0x2801000a..0xfc000000, last on 9th), reg_init_en=1, cpu_halted after 20 RUN cycles -> mem writes to addr 0..8, 31 rf writes k->k, one cpu_clear, done=1, cycles=20.
REQ-035 prog_valid toggled every other cycle during load -> writes only on accepted beats, addresses contiguous 0..N-1.
REQ-036 ADDR_W=2, 4 beats with no prog_last -> ERR, err_code=1, no RINIT/CLEAR. Same with prog_last on 4th beat -> no error.
REQ-037 TIMEOUT=50, cpu_halted held 0 -> ERR, err_code=2, cycles=50, cpu_run=0 after. Halted asserted on cycle 50 -> DONE instead.
REQ-038 abort during RINIT at k=10 -> IDLE next cycle, rf_we=0. Then start -> full sequence restarts at mem_addr 0.
REQ-039 reset pulsed mid-RUN -> all outputs 0 asynchronously, state IDLE, cpu_run=0 before the next edge.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// Load/run sequencer for a small MIPS core: streams a program into instruction
// memory, optionally seeds the register file, clears the core and times its run.
module mips_run_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              reg_init_en,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [31:0]       prog_data,
    input  logic              prog_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [31:0]       rf_wdata,
    output logic              cpu_clear,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RINIT, S_CLEAR, S_RUN, S_DONE, S_ERR
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [4:0]        k, k_n;
    logic [CNT_W-1:0]  cyc_n, cyc_inc;
    logic [1:0]        err_n;
    logic              accept, go, timeout_hit;

    always_comb begin
        accept      = prog_ready && prog_valid;
        go          = start && !abort &&
                      (state == S_IDLE || state == S_DONE || state == S_ERR);
        cyc_inc     = (cycles == '1) ? cycles : cycles + 1'b1;
        timeout_hit = 32'(cyc_inc) >= TIMEOUT;
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: if (start) state_n = S_LOAD;
                S_LOAD: begin
                    // prog_last beats the address-overflow check on the same beat
                    if (accept) begin
                        if (prog_last)      state_n = reg_init_en ? S_RINIT : S_CLEAR;
                        else if (idx == '1) state_n = S_ERR;
                    end
                end
                S_RINIT: if (k == 5'd30) state_n = S_CLEAR;
                S_CLEAR: state_n = S_RUN;
                S_RUN: begin
                    if (cpu_halted)       state_n = S_DONE;
                    else if (timeout_hit) state_n = S_ERR;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        idx_n = idx;
        cyc_n = cycles;
        err_n = err_code;
        k_n   = (state_n == S_RINIT && state == S_RINIT) ? k + 5'd1 : '0;
        if (go) begin
            idx_n = '0;
            cyc_n = '0;
            err_n = '0;
        end else if (!abort) begin
            if (accept)          idx_n = idx + 1'b1;
            if (state == S_RUN)  cyc_n = cyc_inc;
            if (state_n == S_ERR && state != S_ERR)
                err_n = (state == S_LOAD) ? 2'd1 : 2'd2;
        end
    end

    // Every output is a register loaded from next-state values, so the
    // strobes line up with the state they belong to.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            k          <= '0;
            cycles     <= '0;
            err_code   <= '0;
            prog_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rf_we      <= 1'b0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
            cpu_clear  <= 1'b0;
            cpu_run    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            idx        <= idx_n;
            k          <= k_n;
            cycles     <= cyc_n;
            err_code   <= err_n;
            prog_ready <= (state_n == S_LOAD);
            mem_we     <= accept && !abort;
            if (accept) begin
                mem_addr  <= idx;
                mem_wdata <= prog_data;
            end
            rf_we      <= (state_n == S_RINIT);
            rf_addr    <= k_n;
            rf_wdata   <= {27'd0, k_n};
            cpu_clear  <= (state_n == S_CLEAR);
            cpu_run    <= (state_n == S_RUN);
            busy       <= state_n inside {S_LOAD, S_RINIT, S_CLEAR, S_RUN};
            done       <= (state_n == S_DONE);
            error      <= (state_n == S_ERR);
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: a default-width instance and an ADDR_W=2
// instance share stimulus; negedge monitors log every write strobe.
module tb_mips_run_ctrl;

    logic clk1 = 1'b0;
    logic reset, start, abort, reg_init_en, prog_valid, prog_last, cpu_halted;
    logic [31:0] prog_data;

    logic        prog_ready, mem_we, rf_we, cpu_clear, cpu_run, busy, done, error;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, rf_wdata;
    logic [4:0]  rf_addr;
    logic [1:0]  err_code;
    logic [15:0] cycles;

    logic        s_prog_ready, s_mem_we, s_rf_we, s_cpu_clear, s_cpu_run, s_busy, s_done, s_error;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata, s_rf_wdata;
    logic [4:0]  s_rf_addr;
    logic [1:0]  s_err_code;
    logic [15:0] s_cycles;

    logic any_out, s_any_out;
    assign any_out = |{prog_ready, mem_we, mem_addr, mem_wdata, rf_we, rf_addr, rf_wdata,
                       cpu_clear, cpu_run, busy, done, error, err_code, cycles};
    assign s_any_out = |{s_prog_ready, s_mem_we, s_mem_addr, s_mem_wdata, s_rf_we, s_rf_addr,
                         s_rf_wdata, s_cpu_clear, s_cpu_run, s_busy, s_done, s_error,
                         s_err_code, s_cycles};

    mips_run_ctrl #(.ADDR_W(10), .TIMEOUT(50), .CNT_W(16)) u_dut (
        .clk1(clk1), .reset(reset), .start(start), .abort(abort), .reg_init_en(reg_init_en),
        .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_data(prog_data),
        .prog_last(prog_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .cpu_clear(cpu_clear),
        .cpu_run(cpu_run), .cpu_halted(cpu_halted), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .cycles(cycles)
    );

    mips_run_ctrl #(.ADDR_W(2), .TIMEOUT(50), .CNT_W(16)) u_small (
        .clk1(clk1), .reset(reset), .start(start), .abort(abort), .reg_init_en(reg_init_en),
        .prog_valid(prog_valid), .prog_ready(s_prog_ready), .prog_data(prog_data),
        .prog_last(prog_last), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .rf_we(s_rf_we), .rf_addr(s_rf_addr), .rf_wdata(s_rf_wdata), .cpu_clear(s_cpu_clear),
        .cpu_run(s_cpu_run), .cpu_halted(cpu_halted), .busy(s_busy), .done(s_done),
        .error(s_error), .err_code(s_err_code), .cycles(s_cycles)
    );

    always #5 clk1 = ~clk1;

    int nvec = 0;
    int nerr = 0;

    int          wr_n = 0, rf_n = 0, clr_n = 0, clr_bad = 0;
    int          s_wr_n = 0, s_rf_n = 0, s_clr_n = 0;
    logic [9:0]  wr_addr [128];
    logic [31:0] wr_data [128];
    longint      wr_t    [128];
    logic [4:0]  rf_a    [256];
    logic [31:0] rf_d    [256];
    longint      rf_t    [256];
    longint      clr_t = 0;
    logic [1:0]  s_wr_addr [128];

    always @(negedge clk1) begin
        if (mem_we) begin
            if (wr_n < 128) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
                wr_t[wr_n]    = $time;
            end
            wr_n++;
        end
        if (rf_we) begin
            if (rf_n < 256) begin
                rf_a[rf_n] = rf_addr;
                rf_d[rf_n] = rf_wdata;
                rf_t[rf_n] = $time;
            end
            rf_n++;
        end
        if (cpu_clear) begin
            clr_n++;
            clr_t = $time;
            if (cpu_run) clr_bad++;
        end
        if (s_mem_we) begin
            if (s_wr_n < 128) s_wr_addr[s_wr_n] = s_mem_addr;
            s_wr_n++;
        end
        if (s_rf_we)     s_rf_n++;
        if (s_cpu_clear) s_clr_n++;
    end

    logic [31:0] words [16];
    longint      t_acc0 = 0;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic rie);
        reg_init_en = rie;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_prog(input int n, input bit gaps, input bit last_en);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                prog_valid = 1'b0;
                prog_data  = 32'hdeadbeef;
                prog_last  = 1'b1;
                tick();
            end
            prog_valid = 1'b1;
            prog_data  = words[i];
            prog_last  = last_en && (i == n - 1);
            tick();
            if (i == 0) t_acc0 = $time;
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic run_until(input int halt_at, input int budget, output int rc);
        bit fin;
        fin = 1'b0;
        rc  = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            tick();
            if (done || error) begin
                fin = 1'b1;
            end else if (cpu_run) begin
                rc++;
                cpu_halted = (rc == halt_at);
            end
        end
        cpu_halted = 1'b0;
        chk("run_bound", 64'(fin), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  rc;
        bit  found;
        int  wr_b, rf_b, c_b, s_wr_b, s_rf_b, s_c_b;

        words[0] = 32'h2801000a; words[1] = 32'h28020014; words[2] = 32'h00221820;
        words[3] = 32'h00622022; words[4] = 32'hac040000; words[5] = 32'h8c050000;
        words[6] = 32'h10a40001; words[7] = 32'h2806ffff; words[8] = 32'hfc000000;
        for (int i = 9; i < 16; i++) words[i] = 32'ha5a50000 | 32'(i);

        reset = 1'b1; start = 1'b0; abort = 1'b0; reg_init_en = 1'b0;
        prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0; cpu_halted = 1'b0;

        tick();
        chk("rst_outs", 64'(any_out), 64'd0);
        chk("rst_s_outs", 64'(s_any_out), 64'd0);
        tick();
        reset = 1'b0;

        // Idle after reset: beats offered without start are ignored
        prog_valid = 1'b1;
        prog_data  = 32'h12345678;
        repeat (4) tick();
        prog_valid = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(prog_ready), 64'd0);
        chk("idle_nowr", 64'(wr_n), 64'd0);

        // Address overflow on the 2-bit instance
        s_wr_b = s_wr_n; s_rf_b = s_rf_n; s_c_b = s_clr_n;
        do_start(1'b1);
        load_prog(4, 1'b0, 1'b0);
        chk("ovf_error", 64'(s_error), 64'd1);
        chk("ovf_code", 64'(s_err_code), 64'd1);
        chk("ovf_busy", 64'(s_busy), 64'd0);
        repeat (2) tick();
        chk("ovf_wr_cnt", 64'(s_wr_n - s_wr_b), 64'd4);
        chk("ovf_wr_last", 64'(s_wr_addr[s_wr_b + 3]), 64'd3);
        chk("ovf_no_rf", 64'(s_rf_n - s_rf_b), 64'd0);
        chk("ovf_no_clr", 64'(s_clr_n - s_c_b), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_err_off", 64'(s_error), 64'd0);
        chk("abort_code_hold", 64'(s_err_code), 64'd1);
        chk("abort_main_idle", 64'(busy), 64'd0);

        // Same, but prog_last on the 4th beat wins over the overflow
        s_wr_b = s_wr_n;
        do_start(1'b1);
        chk("start_code_clr", 64'(s_err_code), 64'd0);
        load_prog(4, 1'b0, 1'b1);
        chk("last_no_err", 64'(s_error), 64'd0);
        chk("last_code", 64'(s_err_code), 64'd0);
        chk("last_rinit", 64'(s_rf_we), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("last_wr_cnt", 64'(s_wr_n - s_wr_b), 64'd4);

        // Full sequence: 9 words, register init, halt after 20 RUN cycles
        wr_b = wr_n; rf_b = rf_n; c_b = clr_n;
        do_start(1'b1);
        chk("load_ready", 64'(prog_ready), 64'd1);
        chk("load_busy", 64'(busy), 64'd1);
        load_prog(9, 1'b0, 1'b1);
        run_until(20, 300, rc);
        chk("seq_done", 64'(done), 64'd1);
        chk("seq_cycles", 64'(cycles), 64'd20);
        chk("seq_runcnt", 64'(rc), 64'd20);
        chk("seq_run_off", 64'(cpu_run), 64'd0);
        chk("seq_busy", 64'(busy), 64'd0);
        chk("seq_error", 64'(error), 64'd0);
        chk("seq_wr_cnt", 64'(wr_n - wr_b), 64'd9);
        chk("seq_wr_lat", 64'(wr_t[wr_b] - t_acc0), 64'd4);
        for (int i = 0; i < 9; i++) begin
            chk("seq_waddr", 64'(wr_addr[wr_b + i]), 64'(i));
            chk("seq_wdata", 64'(wr_data[wr_b + i]), 64'(words[i]));
        end
        chk("seq_rf_cnt", 64'(rf_n - rf_b), 64'd31);
        for (int k = 0; k < 31; k++) begin
            chk("seq_rf_addr", 64'(rf_a[rf_b + k]), 64'(k));
            chk("seq_rf_data", 64'(rf_d[rf_b + k]), 64'(k));
        end
        chk("seq_rf_span", 64'(rf_t[rf_b + 30] - rf_t[rf_b]), 64'd300);
        chk("seq_clr_cnt", 64'(clr_n - c_b), 64'd1);
        chk("seq_clr_after_rf", 64'(clr_t - rf_t[rf_b + 30]), 64'd10);
        chk("seq_clr_run", 64'(clr_bad), 64'd0);

        // Gapped load (no reg init), then RUN times out at 50
        wr_b = wr_n; rf_b = rf_n; c_b = clr_n;
        do_start(1'b0);
        chk("restart_done_clr", 64'(done), 64'd0);
        load_prog(6, 1'b1, 1'b1);
        run_until(0, 200, rc);
        chk("to_error", 64'(error), 64'd1);
        chk("to_code", 64'(err_code), 64'd2);
        chk("to_cycles", 64'(cycles), 64'd50);
        chk("to_runcnt", 64'(rc), 64'd50);
        chk("to_run_off", 64'(cpu_run), 64'd0);
        chk("to_done", 64'(done), 64'd0);
        chk("gap_wr_cnt", 64'(wr_n - wr_b), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("gap_waddr", 64'(wr_addr[wr_b + i]), 64'(i));
            chk("gap_wdata", 64'(wr_data[wr_b + i]), 64'(words[i]));
        end
        chk("gap_no_rf", 64'(rf_n - rf_b), 64'd0);
        chk("gap_clr_cnt", 64'(clr_n - c_b), 64'd1);

        // Halt on the timeout cycle: halted wins
        do_start(1'b0);
        chk("err_restart_code", 64'(err_code), 64'd0);
        chk("err_restart_flag", 64'(error), 64'd0);
        load_prog(1, 1'b0, 1'b1);
        run_until(50, 200, rc);
        chk("tie_done", 64'(done), 64'd1);
        chk("tie_error", 64'(error), 64'd0);
        chk("tie_code", 64'(err_code), 64'd0);
        chk("tie_cycles", 64'(cycles), 64'd50);

        // Abort in RINIT at k=10 (start held too), then a clean restart
        rf_b = rf_n;
        do_start(1'b1);
        load_prog(3, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            found = rf_we && (rf_addr == 5'd10);
        end
        chk("abt_reach_k10", 64'(found), 64'd1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abt_rf_off", 64'(rf_we), 64'd0);
        chk("abt_busy", 64'(busy), 64'd0);
        chk("abt_ready", 64'(prog_ready), 64'd0);
        repeat (2) tick();
        chk("abt_stay_idle", 64'(busy), 64'd0);
        chk("abt_rf_cnt", 64'(rf_n - rf_b), 64'd11);
        chk("abt_rf_last", 64'(rf_a[rf_b + 10]), 64'd10);
        wr_b = wr_n;
        do_start(1'b0);
        load_prog(2, 1'b0, 1'b1);
        run_until(5, 100, rc);
        chk("rst_seq_wcnt", 64'(wr_n - wr_b), 64'd2);
        chk("rst_seq_addr0", 64'(wr_addr[wr_b]), 64'd0);
        chk("rst_seq_addr1", 64'(wr_addr[wr_b + 1]), 64'd1);
        chk("rst_seq_done", 64'(done), 64'd1);
        chk("rst_seq_cycles", 64'(cycles), 64'd5);

        // Asynchronous reset in the middle of RUN
        do_start(1'b0);
        load_prog(1, 1'b0, 1'b1);
        rc = 0;
        for (int i = 0; i < 40 && rc < 10; i++) begin
            tick();
            if (cpu_run) rc++;
        end
        chk("ar_reach_run", 64'(rc), 64'd10);
        #2 reset = 1'b1;
        #1;
        chk("ar_outs", 64'(any_out), 64'd0);
        chk("ar_run", 64'(cpu_run), 64'd0);
        chk("ar_cycles", 64'(cycles), 64'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("ar_idle_busy", 64'(busy), 64'd0);
        chk("ar_idle_run", 64'(cpu_run), 64'd0);
        chk("ar_idle_ready", 64'(prog_ready), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
